serial_alu_sequencer: RTL and testbench
=======================================

Name: serial_alu_sequencer

Overview:
- Controller that time-multiplexes one combinational 1-bit ALU slice to perform a full WIDTH-bit operation, one bit per clock, LSB first.
- Latches operands and a 4-bit ALU control word on start, drives the slice inputs, and carries Cout between cycles.
- Post-processes SLT and reports result, zero, carry-out and overflow with a start/busy/done handshake.
- Sits between the integer-ALU issue logic and a single shared slice, as an area-reduced alternative to the parallel ripple ALU.

Parameters:
- WIDTH, 64, operand/result width in bits; legal range 2..64.
- CW, $clog2(WIDTH), bit-index counter width (derived, not overridden).

Ports:
- clk  input  1  sole clock; all state changes on rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  request; accepted only in IDLE or DONE
- a_in  input  WIDTH  operand A, sampled on accepted start
- b_in  input  WIDTH  operand B, sampled on accepted start
- alu_ctl  input  4  {Ainvert, Binvert, Op[1:0]}, sampled on accepted start. Op: 0=AND, 1=OR, 2=ADD, 3=SLT
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse in DONE
- result  output  WIDTH  final result, held until next completion
- zero  output  1  result==0, registered with result
- cout  output  1  carry out of MSB
- ovf  output  1  signed overflow, valid for Op=2 only, else 0
- s_a, s_b  output  1 each  slice A, B bits
- s_ainv, s_binv  output  1 each  slice Ain, Bin
- s_op  output  2  slice Op
- s_cin  output  1  slice carry-in
- s_less  output  1  slice Less; tied 0
- s_o, s_cout, s_set, s_ovf  input  1 each  slice outputs O, Cout, Set, Ovf (combinational)

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE; busy, done, result, zero, cout, ovf, internal shift registers, counter and carry all 0. Applies from any state, including mid-RUN; the in-flight operation is discarded with no done.
- States:
  - IDLE: start=1 -> RUN; load a_sr=a_in, b_sr=b_in, ctl=alu_ctl, carry=alu_ctl[2] (Binvert), idx=0.
  - RUN: busy=1. Slice inputs: s_a=a_sr[0], s_b=b_sr[0], s_ainv=ctl[3], s_binv=ctl[2], s_op=ctl[1:0], s_cin=carry, s_less=0.
    - Each edge: shift a_sr and b_sr right; shift s_o into work-register MSB (shift right); carry<=s_cout; idx++.
    - When idx==WIDTH-1 (MSB cycle), -> DONE and commit:
      - result = shifted work value (final s_o included), except Op=3, where result = {WIDTH-1 zeros, s_set ^ s_ovf} (true signed less-than).
      - zero = (committed result==0).
      - cout = s_cout.
      - ovf = s_ovf if Op==2, else 0.
    - start ignored in RUN.
  - DONE: done=1 for exactly one cycle. start=1 -> RUN with a fresh load (back-to-back; done still pulses this cycle). Otherwise -> IDLE.
- Slice outputs in IDLE/DONE: s_a, s_b, s_ainv, s_binv, s_cin = 0; s_op = 0.
- Latency: start accepted at edge N; done high in cycle N+WIDTH+1. Throughput one op per WIDTH+1 cycles.
- result/flags change only at the commit edge or reset; stable through the next RUN.
- SUB = ctl 4'b0110 (Cin=1 via Binvert). NOR = 4'b1100. Any 4-bit code executes; behaviour is whatever the slice computes, with the Op=3 post-processing above.
- Input changes on a_in, b_in, alu_ctl after acceptance have no effect.

Test Plan:
- ADD (ctl 0010) a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> result 0x8000_0000_0000_0000, ovf=1, cout=0, zero=0; done exactly 65 cycles after the start edge.
- SUB (0110) a=5, b=5 -> result 0, zero=1, cout=1, ovf=0. SUB a=0, b=1 -> result 0xFFFF_FFFF_FFFF_FFFF, cout=0.
- SLT (0111): a=-1, b=1 -> result 1. a=1, b=-1 -> 0. a=0x8000_0000_0000_0000, b=1 (overflow case) -> 1. ovf output 0 in all three.
- Logic with a=0xF0F0_F0F0_F0F0_F0F0, b=0xFF00_FF00_FF00_FF00:
  - AND (0000) -> 0xF000_F000_F000_F000
  - OR (0001) -> 0xFFF0_FFF0_FFF0_FFF0
  - NOR (1100) -> 0x000F_000F_000F_000F
- Handshake: start pulsed at cycle 10 of RUN -> ignored, operands unchanged. start asserted in the DONE cycle -> new op accepted, busy next cycle, second done 65 cycles later, first result held until second commit.
- Reset mid-op: rst_n=0 for one edge at idx=30 -> IDLE, busy=0, done never pulses, result/zero/cout/ovf=0. Subsequent ADD 3+4 -> 7.

Source files
------------

// File: rtl/serial_alu_sequencer_if.sv
// -----------------------------------------------------------------------------
// serial_alu_sequencer_if
// Request/response bundle between the integer-ALU issue logic (master) and the
// bit-serial ALU sequencer (slave).
//
// Signals:
//   start    master->slave  request, honoured only when the sequencer is idle/done
//   a_in     master->slave  operand A
//   b_in     master->slave  operand B
//   alu_ctl  master->slave  {Ainvert, Binvert, Op[1:0]}
//   busy     slave->master  operation in progress
//   done     slave->master  one-cycle completion pulse
//   result   slave->master  committed result
//   zero     slave->master  committed result == 0
//   cout     slave->master  carry out of the MSB
//   ovf      slave->master  signed overflow (ADD only)
// -----------------------------------------------------------------------------
interface serial_alu_sequencer_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [3:0]       alu_ctl;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a_in, b_in, alu_ctl,
        input  busy, done, result, zero, cout, ovf
    );

    modport slave (
        input  start, a_in, b_in, alu_ctl,
        output busy, done, result, zero, cout, ovf
    );
endinterface

// File: rtl/serial_alu_sequencer.sv
// -----------------------------------------------------------------------------
// serial_alu_sequencer
// Time-multiplexes a single combinational 1-bit ALU slice to execute a full
// WIDTH-bit operation, one bit per clock, LSB first. Operands and the control
// word are latched when a request is accepted; the slice carry-out is fed back
// as the next carry-in. SLT is resolved at the MSB as Set ^ Ovf.
//
// Ports:
//   clk      sole clock, rising edge
//   rst_n    synchronous active-low reset
//   bus      request/response interface (slave side)
//   s_a, s_b, s_ainv, s_binv, s_op, s_cin, s_less   drive the shared slice
//   s_o, s_cout, s_set, s_ovf                        slice outputs (combinational)
//
// State  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start
// RUN    | one bit per cycle through the slice; commit on the MSB cycle
// DONE   | one-cycle done pulse; start here chains straight into RUN
// -----------------------------------------------------------------------------
module serial_alu_sequencer #(
    parameter int WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    serial_alu_sequencer_if.slave        bus,
    output logic                         s_a,
    output logic                         s_b,
    output logic                         s_ainv,
    output logic                         s_binv,
    output logic [1:0]                   s_op,
    output logic                         s_cin,
    output logic                         s_less,
    input  logic                         s_o,
    input  logic                         s_cout,
    input  logic                         s_set,
    input  logic                         s_ovf
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_work;
    logic [3:0]       r_ctl;
    logic             r_carry;
    logic [CW-1:0]    r_idx;

    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_cout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic             w_busy;
    logic             w_done;
    logic [WIDTH-1:0] w_work_shifted;
    logic [WIDTH-1:0] w_commit_result;
    logic             w_commit_zero;
    logic             w_commit_ovf;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state, handshake and slice drive
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        s_a         = 1'b0;
        s_b         = 1'b0;
        s_ainv      = 1'b0;
        s_binv      = 1'b0;
        s_op        = 2'b00;
        s_cin       = 1'b0;
        s_less      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_busy = 1'b1;
                w_step = 1'b1;
                s_a    = r_a_sr[0];
                s_b    = r_b_sr[0];
                s_ainv = r_ctl[3];
                s_binv = r_ctl[2];
                s_op   = r_ctl[1:0];
                s_cin  = r_carry;
                if (r_idx == LAST_IDX) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done = 1'b1;
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Commit values, valid only on the MSB cycle. The work register
    // fills from the top, so after WIDTH shifts bit 0 sits at the LSB.
    // SLT uses the sign of A-B corrected by overflow, which gives the
    // true signed comparison even when the subtraction wraps.
    // ------------------------------------------------------------------
    assign w_work_shifted  = {s_o, r_work[WIDTH-1:1]};
    assign w_commit_result = (r_ctl[1:0] == 2'b11)
                           ? {{(WIDTH-1){1'b0}}, s_set ^ s_ovf}
                           : w_work_shifted;
    assign w_commit_zero   = (w_commit_result == '0);
    assign w_commit_ovf    = (r_ctl[1:0] == 2'b10) & s_ovf;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_work   <= '0;
            r_ctl    <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a_sr  <= bus.a_in;
            r_b_sr  <= bus.b_in;
            r_work  <= '0;
            r_ctl   <= bus.alu_ctl;
            // Binvert doubles as the +1 of two's-complement subtraction.
            r_carry <= bus.alu_ctl[2];
            r_idx   <= '0;
        end else if (w_step) begin
            r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_work  <= w_work_shifted;
            r_carry <= s_cout;
            r_idx   <= r_idx + CW'(1);
            if (w_last) begin
                r_result <= w_commit_result;
                r_zero   <= w_commit_zero;
                r_cout   <= s_cout;
                r_ovf    <= w_commit_ovf;
            end
        end
    end

    assign bus.busy   = w_busy;
    assign bus.done   = w_done;
    assign bus.result = r_result;
    assign bus.zero   = r_zero;
    assign bus.cout   = r_cout;
    assign bus.ovf    = r_ovf;

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_serial_alu_sequencer
// Directed bench for serial_alu_sequencer (WIDTH=64) with a behavioural 1-bit
// slice. Stimulus pushes expected responses into a queue; a monitor pops and
// compares on every done pulse, including completion latency.
// -----------------------------------------------------------------------------
module tb_serial_alu_sequencer;

    localparam int WIDTH = 64;

    logic clk;
    logic rst_n;
    logic s_a, s_b, s_ainv, s_binv, s_cin, s_less;
    logic [1:0] s_op;
    logic s_o, s_cout, s_set, s_ovf;
    logic w_sa, w_sb, w_sum;

    serial_alu_sequencer_if #(.WIDTH(WIDTH)) bus_if ();

    serial_alu_sequencer #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus_if),
        .s_a    (s_a),
        .s_b    (s_b),
        .s_ainv (s_ainv),
        .s_binv (s_binv),
        .s_op   (s_op),
        .s_cin  (s_cin),
        .s_less (s_less),
        .s_o    (s_o),
        .s_cout (s_cout),
        .s_set  (s_set),
        .s_ovf  (s_ovf)
    );

    // Classic 1-bit ALU slice: invert, AND/OR/ADD/LESS mux, Set = sum,
    // Ovf = carry-in ^ carry-out (meaningful at the MSB).
    always_comb begin
        w_sa   = s_a ^ s_ainv;
        w_sb   = s_b ^ s_binv;
        w_sum  = w_sa ^ w_sb ^ s_cin;
        s_cout = (w_sa & w_sb) | (w_sa & s_cin) | (w_sb & s_cin);
        s_set  = w_sum;
        s_ovf  = s_cin ^ s_cout;
        case (s_op)
            2'd0:    s_o = w_sa & w_sb;
            2'd1:    s_o = w_sa | w_sb;
            2'd2:    s_o = w_sum;
            default: s_o = s_less;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        logic        z;
        logic        c;
        logic        v;
        int          done_cyc;
        int          tag;
    } exp_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  ctl;
        logic [63:0] res;
        logic        z;
        logic        c;
        logic        v;
    } vec_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   next_tag = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected response.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (bus_if.done === 1'b1) begin
            check("done_single_pulse", {63'd0, prev_done}, 64'd0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
            end else begin
                e = q.pop_front();
                check($sformatf("op%0d_result", e.tag), bus_if.result, e.res);
                check($sformatf("op%0d_zero", e.tag), {63'd0, bus_if.zero}, {63'd0, e.z});
                check($sformatf("op%0d_cout", e.tag), {63'd0, bus_if.cout}, {63'd0, e.c});
                check($sformatf("op%0d_ovf", e.tag), {63'd0, bus_if.ovf}, {63'd0, e.v});
                check($sformatf("op%0d_latency_cycle", e.tag), 64'(cyc), 64'(e.done_cyc));
            end
        end
        prev_done = (bus_if.done === 1'b1);
    end

    // Call at a negedge; start is sampled on the following posedge.
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [3:0] ctl,
                         input logic [63:0] er, input logic ez, input logic ec, input logic ev);
        exp_t e;
        bus_if.a_in    = a;
        bus_if.b_in    = b;
        bus_if.alu_ctl = ctl;
        bus_if.start   = 1'b1;
        e.res      = er;
        e.z        = ez;
        e.c        = ec;
        e.v        = ev;
        e.done_cyc = cyc + WIDTH + 1;
        e.tag      = next_tag;
        next_tag++;
        q.push_back(e);
        @(posedge clk);
        #1;
        bus_if.start   = 1'b0;
        // Scramble inputs: the latched copy must be the only one used.
        bus_if.a_in    = ~a;
        bus_if.b_in    = ~b;
        bus_if.alu_ctl = ~ctl;
    endtask

    // Returns at the negedge where done is high.
    task automatic wait_done(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus_if.done !== 1'b1 && n < 200);
        if (bus_if.done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done in %0d cycles expected done", nm, n);
        end
    endtask

    vec_t vecs[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 4'b0010, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{64'h5, 64'h5, 4'b0110, 64'h0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{64'h0, 64'h1, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 4'b0111, 64'h1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0111, 64'h0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{64'h8000_0000_0000_0000, 64'h1, 4'b0111, 64'h1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 4'b0000, 64'hF000_F000_F000_F000, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 4'b0001, 64'hFFF0_FFF0_FFF0_FFF0, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 4'b1100, 64'h000F_000F_000F_000F, 1'b0, 1'b0, 1'b0};

        rst_n          = 1'b0;
        bus_if.start   = 1'b0;
        bus_if.a_in    = '0;
        bus_if.b_in    = '0;
        bus_if.alu_ctl = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",   {63'd0, bus_if.busy}, 64'd0);
        check("rst_done",   {63'd0, bus_if.done}, 64'd0);
        check("rst_result", bus_if.result, 64'd0);
        check("rst_flags",  {60'd0, bus_if.zero, bus_if.cout, bus_if.ovf, s_less}, 64'd0);
        check("rst_slice",  {58'd0, s_a, s_b, s_ainv, s_binv, s_op}, 64'd0);
        rst_n = 1'b1;

        // Directed operation table.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            issue(vecs[i].a, vecs[i].b, vecs[i].ctl, vecs[i].res, vecs[i].z, vecs[i].c, vecs[i].v);
            @(negedge clk);
            check($sformatf("vec%0d_busy", i), {63'd0, bus_if.busy}, 64'd1);
            check($sformatf("vec%0d_slice_ctl", i), {60'd0, s_ainv, s_binv, s_op}, {60'd0, vecs[i].ctl});
            wait_done($sformatf("vec%0d", i));
        end

        // start during RUN is ignored.
        @(negedge clk);
        issue(64'h1234, 64'h1111, 4'b0010, 64'h2345, 1'b0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        bus_if.start   = 1'b1;
        bus_if.a_in    = 64'hDEAD_BEEF_0000_0000;
        bus_if.alu_ctl = 4'b0001;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        @(negedge clk);
        check("run_start_ignored_busy", {63'd0, bus_if.busy}, 64'd1);
        wait_done("ignore_start");

        // Back-to-back: start in the DONE cycle.
        @(negedge clk);
        issue(64'h64, 64'h17, 4'b0010, 64'h7B, 1'b0, 1'b0, 1'b0);
        wait_done("b2b_first");
        issue(64'd10, 64'd3, 4'b0110, 64'd7, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("b2b_busy_next", {63'd0, bus_if.busy}, 64'd1);
        check("b2b_hold_early", bus_if.result, 64'h7B);
        repeat (30) @(negedge clk);
        check("b2b_hold_mid", bus_if.result, 64'h7B);
        wait_done("b2b_second");

        // Reset in the middle of an operation.
        @(negedge clk);
        issue(64'hFF, 64'h1, 4'b0010, 64'h100, 1'b0, 1'b0, 1'b0);
        repeat (30) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        @(negedge clk);
        check("midrst_busy",   {63'd0, bus_if.busy}, 64'd0);
        check("midrst_done",   {63'd0, bus_if.done}, 64'd0);
        check("midrst_result", bus_if.result, 64'd0);
        check("midrst_flags",  {61'd0, bus_if.zero, bus_if.cout, bus_if.ovf}, 64'd0);
        repeat (80) @(negedge clk);
        check("midrst_idle_busy", {63'd0, bus_if.busy}, 64'd0);
        issue(64'd3, 64'd4, 4'b0010, 64'd7, 1'b0, 1'b0, 1'b0);
        wait_done("post_reset_add");

        repeat (5) @(negedge clk);
        check("queue_drained", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
